// File: rtl/bwm_pkg.sv
// Shared constants and reference helpers for the Baugh-Wooley multiplier.
// BWM_INPUT_REG_EN selects the latency constant (input register stage present).
package bwm_pkg;

  localparam int BWM_DEFAULT_W = 4;

`ifdef BWM_INPUT_REG_EN
  localparam int BWM_LATENCY = 2;
`else
  localparam int BWM_LATENCY = 1;
`endif

  // Reference signed product; operands must be sign-extended to 16 bits by the caller.
  function automatic logic signed [31:0] bwm_ref_mul(input logic signed [15:0] a,
                                                     input logic signed [15:0] b);
    return a * b;
  endfunction

endpackage

// File: rtl/bwm_fa.sv
// Single full-adder cell used for both the carry-save rows and the final ripple adder.
module bwm_fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/baugh_wooley_multiplier.sv
// Signed W x W -> 2W Baugh-Wooley array multiplier with a registered product.
// Define BWM_INPUT_REG_EN to add a reset-cleared input register stage (latency 2).
module baugh_wooley_multiplier
  import bwm_pkg::*;
#(
  parameter int W = BWM_DEFAULT_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  input  logic [W-1:0]   x,
  input  logic [W-1:0]   y,
  output logic           out_valid,
  output logic [2*W-1:0] z
);

  localparam int PW = 2 * W;
  // Baugh-Wooley correction constant: ones at columns W and 2W-1.
  localparam logic [PW-1:0] CST = (PW'(1) << W) | (PW'(1) << (PW - 1));

  logic [W-1:0] x_q;
  logic [W-1:0] y_q;
  logic         v_q;

`ifdef BWM_INPUT_REG_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
      v_q <= 1'b0;
    end else begin
      v_q <= in_valid;
      if (in_valid) begin
        x_q <= x;
        y_q <= y;
      end
    end
  end
`else
  assign x_q = x;
  assign y_q = y;
  assign v_q = in_valid;
`endif

  // Partial-product rows, each already shifted into its column position.
  logic [PW-1:0] row [W];

  always_comb begin
    for (int i = 0; i < W; i++) begin
      row[i] = '0;
      for (int j = 0; j < W; j++) begin
        row[i][i+j] = (x_q[j] & y_q[i]) ^ ((i == W - 1) != (j == W - 1));
      end
    end
  end

  // Carry-save accumulation: row 0 and the constant seed the sum/carry pair.
  logic [PW-1:0] sum_v [W];
  logic [PW-1:0] cy_v  [W];

  assign sum_v[0] = row[0];
  assign cy_v[0]  = CST;

  generate
    for (genvar i = 1; i < W; i++) begin : g_row
      logic [PW-2:0] co_v;

      for (genvar j = 0; j < PW - 1; j++) begin : g_col
        bwm_fa u_fa (
          .a    (sum_v[i-1][j]),
          .b    (cy_v[i-1][j]),
          .cin  (row[i][j]),
          .s    (sum_v[i][j]),
          .cout (co_v[j])
        );
      end

      // Top column's carry would leave the 2W-bit result, so only its sum is kept.
      assign sum_v[i][PW-1] = sum_v[i-1][PW-1] ^ cy_v[i-1][PW-1] ^ row[i][PW-1];
      assign cy_v[i]        = {co_v, 1'b0};
    end
  endgenerate

  // Final ripple-carry adder resolving the last sum/carry pair.
  logic [PW-1:0] rc;
  logic [PW-1:0] prod;

  assign rc[0] = 1'b0;

  generate
    for (genvar j = 0; j < PW - 1; j++) begin : g_rca
      bwm_fa u_fa (
        .a    (sum_v[W-1][j]),
        .b    (cy_v[W-1][j]),
        .cin  (rc[j]),
        .s    (prod[j]),
        .cout (rc[j+1])
      );
    end
  endgenerate

  assign prod[PW-1] = sum_v[W-1][PW-1] ^ cy_v[W-1][PW-1] ^ rc[PW-1];

  // z only loads on a valid sample, so undriven operands never reach it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      z         <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= v_q;
      if (v_q) begin
        z <= prod;
      end
    end
  end

  logic signed [15:0] ref_a;
  logic signed [15:0] ref_b;

  assign ref_a = 16'($signed(x_q));
  assign ref_b = 16'($signed(y_q));

  always @(posedge clk) begin
    if (rst_n && v_q) begin
      assert ($signed(prod) == bwm_ref_mul(ref_a, ref_b))
        else $error("array product %h disagrees with reference", prod);
    end
  end

endmodule

// File: tb/tb_baugh_wooley_multiplier.sv
// Directed and sweep bench for baugh_wooley_multiplier at W=4 and W=8.
// Latency follows BWM_LATENCY so the same bench covers both builds.
module tb_baugh_wooley_multiplier;
  import bwm_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid4, out_valid4;
  logic [3:0]  x4, y4;
  logic [7:0]  z4;
  logic        in_valid8, out_valid8;
  logic [7:0]  x8, y8;
  logic [15:0] z8;

  baugh_wooley_multiplier #(.W(4)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid4),
    .x         (x4),
    .y         (y4),
    .out_valid (out_valid4),
    .z         (z4)
  );

  baugh_wooley_multiplier #(.W(8)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid8),
    .x         (x8),
    .y         (y8),
    .out_valid (out_valid8),
    .z         (z8)
  );

  // scoreboard: expected queues delayed by the pipeline depth
  logic        exp_v4_q[$];
  logic [7:0]  exp_q4[$];
  logic        exp_v8_q[$];
  logic [15:0] exp_q8[$];
  logic        m4_v, m8_v;
  logic [7:0]  m4_z;
  logic [15:0] m8_z;
  int          n_vec = 0;
  int          n_bad = 0;

  task automatic model_reset();
    exp_v4_q.delete(); exp_q4.delete();
    exp_v8_q.delete(); exp_q8.delete();
    for (int k = 0; k < BWM_LATENCY - 1; k++) begin
      exp_v4_q.push_back(1'b0); exp_q4.push_back('0);
      exp_v8_q.push_back(1'b0); exp_q8.push_back('0);
    end
    m4_v = 1'b0; m4_z = '0;
    m8_v = 1'b0; m8_z = '0;
  endtask

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
      $error("check %s", tag);
    end
  endtask

  // One clock: drive both DUTs at negedge, advance the model at posedge, compare.
  task automatic tick(input string tag,
                      input logic v4, input logic [3:0] a4, input logic [3:0] b4,
                      input logic [7:0] e4,
                      input logic v8, input logic [7:0] a8, input logic [7:0] b8,
                      input logic [15:0] e8);
    logic ev;
    logic [7:0]  ez4;
    logic [15:0] ez8;
    @(negedge clk);
    in_valid4 = v4; x4 = a4; y4 = b4;
    in_valid8 = v8; x8 = a8; y8 = b8;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      model_reset();
    end else begin
      exp_v4_q.push_back(v4); exp_q4.push_back(e4);
      exp_v8_q.push_back(v8); exp_q8.push_back(e8);
      ev = exp_v4_q.pop_front(); ez4 = exp_q4.pop_front();
      m4_v = ev;
      if (ev) m4_z = ez4;
      ev = exp_v8_q.pop_front(); ez8 = exp_q8.pop_front();
      m8_v = ev;
      if (ev) m8_z = ez8;
    end
    check({tag, ".z4"},  {8'h00, z4},        {8'h00, m4_z});
    check({tag, ".ov4"}, {15'h0, out_valid4}, {15'h0, m4_v});
    check({tag, ".z8"},  z8,                 m8_z);
    check({tag, ".ov8"}, {15'h0, out_valid8}, {15'h0, m8_v});
  endtask

  task automatic tick4(input string tag, input logic v, input logic [3:0] a,
                       input logic [3:0] b, input logic [7:0] e);
    tick(tag, v, a, b, e, 1'b0, 8'h00, 8'h00, 16'h0000);
  endtask

  initial begin
    int p;
    logic [3:0] a, b;
    logic [7:0] ra, rb;
    in_valid4 = 1'b0; x4 = '0; y4 = '0;
    in_valid8 = 1'b0; x8 = '0; y8 = '0;
    model_reset();

    // reset held 3 cycles with a valid operand pair presented
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) tick4("reset", 1'b1, 4'h7, 4'h7, 8'h31);
    rst_n = 1'b1;
    tick4("first", 1'b1, 4'h7, 4'h7, 8'h31);
    tick4("idle0", 1'b0, 4'h0, 4'h0, 8'h00);
    tick4("idle1", 1'b0, 4'h0, 4'h0, 8'h00);

    // corner values
    tick4("m8xm8", 1'b1, 4'h8, 4'h8, 8'h40);
    tick4("m8x7",  1'b1, 4'h8, 4'h7, 8'hC8);
    tick4("7x7",   1'b1, 4'h7, 4'h7, 8'h31);
    tick4("m1xm1", 1'b1, 4'hF, 4'hF, 8'h01);
    tick4("0xm8",  1'b1, 4'h0, 4'h8, 8'h00);

    // streaming back-to-back
    tick4("s0", 1'b1, 4'h3, 4'hE, 8'hFA);
    tick4("s1", 1'b1, 4'hB, 4'h4, 8'hEC);
    tick4("s2", 1'b1, 4'h6, 4'h6, 8'h24);
    tick4("s3", 1'b1, 4'hF, 4'h7, 8'hF9);

    // hold with changing operands while invalid
    tick4("h0", 1'b1, 4'h5, 4'hD, 8'hF1);
    for (int k = 0; k < 6; k++)
      tick4("hold", 1'b0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 8'h00);

    // exhaustive W=4 sweep
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        a = 4'(i); b = 4'(j);
        p = $signed(a) * $signed(b);
        tick4("sweep", 1'b1, a, b, p[7:0]);
      end
    end

    // random W=8 vectors, with occasional idle cycles
    for (int k = 0; k < 3000; k++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      if (k % 10 == 0) begin
        ra = 8'h80;
        rb = (k % 20 == 0) ? 8'h80 : 8'h7F;
      end
      p = $signed(ra) * $signed(rb);
      tick("rand8", 1'b0, 4'h0, 4'h0, 8'h00,
           ($urandom_range(0, 7) != 0), ra, rb, p[15:0]);
    end

    for (int k = 0; k < 3; k++) tick4("flush", 1'b0, 4'h0, 4'h0, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
